miss_refill_ctrl: RTL and testbench
===================================

// Module: miss_refill_ctrl
// PURPOSE
//  Memory-side responder for cache misses raised by the IF stage (I-cache) and the MA stage (D-cache).
//  Accepts a held miss request and fetches the missed line word by word from main memory.
//  Returns each word to the requesting cache as a fill write, then pulses done so the stall unit releases.
//  Sits between both caches and the single main-memory read port.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  word width
//  LINE_WORDS  4   words per cache line; power of two, >=2
// PORTS
//  Clk          in   1       clock, rising edge
//  Rst          in   1       asynchronous, active-high reset
//  i_IReq       in   1       I-cache miss; level, held until o_IDone
//  i_IAddr      in   ADDR_W  I-cache missed byte address
//  i_DReq       in   1       D-cache miss; level, held until o_DDone
//  i_DAddr      in   ADDR_W  D-cache missed byte address
//  o_MemRd      out  1       memory word read request
//  o_MemAddr    out  ADDR_W  memory word address (word aligned)
//  i_MemValid   in   1       read data valid; completes the current o_MemRd
//  i_MemData    in   DATA_W  read data
//  o_Fill_Data  out  DATA_W  fill word to caches (shared bus)
//  o_Fill_Idx   out  log2(LINE_WORDS)  word index within line
//  o_IFill_We   out  1       write o_Fill_Data into I-cache line
//  o_DFill_We   out  1       write o_Fill_Data into D-cache line
//  o_IDone      out  1       one-cycle pulse: I line complete
//  o_DDone      out  1       one-cycle pulse: D line complete
// BEHAVIOUR
//  - All outputs registered; Rst clears every output to 0, FSM to IDLE, counters to 0.
//  - FSM IDLE -> RD -> WAIT -> (RD | IDLE).
//  - IDLE: D has priority over I; a simultaneous i_DReq and i_IReq grants D. Latch the owner, the line base (addr & ~line mask) and the start index.
//  - The grant cycle is followed by o_MemRd=1 on the next cycle.
//  - RD/WAIT: o_MemRd and o_MemAddr stay stable until the cycle i_MemValid=1.
//  - o_MemAddr = {line base, idx, 2'b00}.
//  - i_MemValid ignored when o_MemRd=0.
//  - On i_MemValid, the next cycle presents: o_Fill_Data=i_MemData, o_Fill_Idx=idx, and the owner's Fill_We for 1 cycle.
//  - idx advances modulo LINE_WORDS. o_MemRd drops for that one cycle, then reasserts for the next word.
//  - The last word's fill cycle also carries the owner's Done pulse. The FSM then returns to IDLE.
//  - Minimum turnaround is 1 idle cycle before a new grant, so a request still held during the Done cycle is not regranted.
//  - Owner's Req deasserts mid-line (flush):
//     - the outstanding memory read completes, but its fill write is suppressed;
//     - no Done pulse;
//     - FSM returns to IDLE.
//  - The non-owner's request waits; it is never preempted.
//  - Reset mid-line: abandons immediately; no fill or done afterwards.
//  - Fill_We and Done never assert for both caches in the same cycle.
//  - The missed address's low byte bits are ignored.
// CONFIGURATION
//  - MISS_REFILL_CRIT_FIRST_EN defined: start idx = missed word index; wrap to 0 after LINE_WORDS-1; done after LINE_WORDS words.
//  - Not defined: start idx = 0, ascending order.
//  - Word count, handshake and latency are identical in both builds.
// STRUCTURE
//  - Package refill_pkg:
//     - FSM state encoding (IDLE, RD, WAIT);
//     - owner encoding (OWN_I, OWN_D);
//     - localparam IDX_W = $clog2(LINE_WORDS).
//  - Sub-module refill_word_ctr: loadable wrapping index counter plus word count.
//     - Inputs: load, start, step.
//     - Outputs: idx, last.
//  - FSM, arbitration and output registers live in miss_refill_ctrl.
// TESTING
//  - Single I miss:
//     - stimulus: i_IAddr=0x104, memory answers 2 cycles after each o_MemRd (no CRIT_FIRST);
//     - response: o_MemAddr 0x100, 0x104, 0x108, 0x10C; four o_IFill_We with Idx 0..3; o_IDone coincident with Idx 3.
//  - Critical-first:
//     - stimulus: same miss built with MISS_REFILL_CRIT_FIRST_EN;
//     - response: addresses 0x104, 0x108, 0x10C, 0x100; Idx 1, 2, 3, 0; o_IDone with Idx 0.
//  - Simultaneous misses:
//     - stimulus: i_IReq and i_DReq rise in the same cycle;
//     - response: full D line first, one idle cycle, then the I line; no overlap of Fill_We.
//  - Flush mid-line:
//     - stimulus: i_IReq drops after the second fill;
//     - response: the in-flight read completes with no fill, no o_IDone, FSM back in IDLE; a pending D request is granted next.
//  - Memory stall:
//     - stimulus: i_MemValid held low 10 cycles;
//     - response: o_MemRd/o_MemAddr stable throughout; no fills.
//  - Async reset:
//     - stimulus: Rst asserted between the clock edges during WAIT;
//     - response: all outputs 0 immediately; no fill after release.

Source files
------------

// File: rtl/miss_refill_ctrl_pkg.sv
// Shared state and owner encodings for the cache-miss refill controller.
package refill_pkg;
  localparam int LINE_WORDS_DFLT = 4;
  localparam int IDX_W = $clog2(LINE_WORDS_DFLT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;
endpackage

// File: rtl/miss_refill_ctrl_word_ctr.sv
// Loadable wrapping word-index counter with a words-transferred count for one line.
module refill_word_ctr
  import refill_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DFLT,
  localparam int IW = $clog2(LINE_WORDS)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          load,
  input  logic [IW-1:0] start,
  input  logic          step,
  output logic [IW-1:0] idx,
  output logic          last
);
  logic [IW-1:0] idx_q;
  logic [IW-1:0] cnt_q;

  // Line size is a power of two, so natural overflow gives the modulo wrap.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      idx_q <= start;
      cnt_q <= '0;
    end else if (step) begin
      idx_q <= idx_q + IW'(1);
      cnt_q <= cnt_q + IW'(1);
    end
  end

  assign idx  = idx_q;
  assign last = (cnt_q == IW'(LINE_WORDS - 1));
endmodule

// File: rtl/miss_refill_ctrl.sv
// Refills I/D cache lines from the single memory read port, one word per read.
// Define MISS_REFILL_CRIT_FIRST_EN to start each line at the missed word.
//
// state   | meaning
// IDLE    | no line in progress; arbitrate (D over I)
// RD      | o_MemRd held, waiting for i_MemValid
// WAIT    | fill word presented; issue next read or finish
module miss_refill_ctrl
  import refill_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = LINE_WORDS_DFLT,
  localparam int IW = $clog2(LINE_WORDS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_IReq,
  input  logic [ADDR_W-1:0] i_IAddr,
  input  logic              i_DReq,
  input  logic [ADDR_W-1:0] i_DAddr,
  output logic              o_MemRd,
  output logic [ADDR_W-1:0] o_MemAddr,
  input  logic              i_MemValid,
  input  logic [DATA_W-1:0] i_MemData,
  output logic [DATA_W-1:0] o_Fill_Data,
  output logic [IW-1:0]     o_Fill_Idx,
  output logic              o_IFill_We,
  output logic              o_DFill_We,
  output logic              o_IDone,
  output logic              o_DDone
);
  localparam int LOFF = IW + 2;
  localparam int BW   = ADDR_W - LOFF;

  state_e            state_q;
  owner_e            owner_q;
  logic [BW-1:0]     base_q;
  logic              flush_q;
  logic              fin_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] fill_data_q;
  logic [IW-1:0]     fill_idx_q;
  logic              ifill_we_q;
  logic              dfill_we_q;
  logic              idone_q;
  logic              ddone_q;

  logic              grant;
  logic              sel_dcache;
  logic              owner_req;
  logic              accept;
  logic              fill_ok;
  logic [ADDR_W-1:0] req_addr;
  logic [IW-1:0]     start_idx;
  logic [IW-1:0]     ctr_idx;
  logic              ctr_last;
  logic              unused_addr_bits;

  assign grant      = (state_q == ST_IDLE) && (i_DReq || i_IReq);
  assign sel_dcache = i_DReq;
  assign req_addr   = sel_dcache ? i_DAddr : i_IAddr;
  assign owner_req  = (owner_q == OWN_D) ? i_DReq : i_IReq;
  assign accept     = (state_q == ST_RD) && i_MemValid;
  assign fill_ok    = !flush_q && owner_req;

`ifdef MISS_REFILL_CRIT_FIRST_EN
  assign start_idx = req_addr[LOFF-1:2];
`else
  assign start_idx = '0;
`endif
  assign unused_addr_bits = ^req_addr[LOFF-1:0];

  refill_word_ctr #(.LINE_WORDS(LINE_WORDS)) u_word_ctr (
    .Clk  (Clk),
    .Rst  (Rst),
    .load (grant),
    .start(start_idx),
    .step (accept),
    .idx  (ctr_idx),
    .last (ctr_last)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      base_q      <= '0;
      flush_q     <= 1'b0;
      fin_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      fill_data_q <= '0;
      fill_idx_q  <= '0;
      ifill_we_q  <= 1'b0;
      dfill_we_q  <= 1'b0;
      idone_q     <= 1'b0;
      ddone_q     <= 1'b0;
    end else begin
      ifill_we_q <= 1'b0;
      dfill_we_q <= 1'b0;
      idone_q    <= 1'b0;
      ddone_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            owner_q    <= sel_dcache ? OWN_D : OWN_I;
            base_q     <= req_addr[ADDR_W-1:LOFF];
            mem_addr_q <= {req_addr[ADDR_W-1:LOFF], start_idx, 2'b00};
            mem_rd_q   <= 1'b1;
            flush_q    <= 1'b0;
            fin_q      <= 1'b0;
            state_q    <= ST_RD;
          end
        end
        ST_RD: begin
          // A dropped request mid-read is sticky: the read still completes but is discarded.
          if (!owner_req) flush_q <= 1'b1;
          if (i_MemValid) begin
            mem_rd_q <= 1'b0;
            state_q  <= ST_WAIT;
            if (fill_ok) begin
              fill_data_q <= i_MemData;
              fill_idx_q  <= ctr_idx;
              ifill_we_q  <= (owner_q == OWN_I);
              dfill_we_q  <= (owner_q == OWN_D);
              idone_q     <= (owner_q == OWN_I) && ctr_last;
              ddone_q     <= (owner_q == OWN_D) && ctr_last;
              fin_q       <= ctr_last;
            end
          end
        end
        ST_WAIT: begin
          if (fin_q || flush_q || !owner_req) begin
            state_q <= ST_IDLE;
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {base_q, ctr_idx, 2'b00};
            state_q    <= ST_RD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_MemRd     = mem_rd_q;
  assign o_MemAddr   = mem_addr_q;
  assign o_Fill_Data = fill_data_q;
  assign o_Fill_Idx  = fill_idx_q;
  assign o_IFill_We  = ifill_we_q;
  assign o_DFill_We  = dfill_we_q;
  assign o_IDone     = idone_q;
  assign o_DDone     = ddone_q;
endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Self-checking bench for miss_refill_ctrl: directed line table, corner sequences, random traffic vs a line-level model.
`timescale 1ns/1ps
module tb_miss_refill_ctrl;
  localparam int LW = 4;
`ifdef MISS_REFILL_CRIT_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        i_IReq, i_DReq, i_MemValid;
  logic [31:0] i_IAddr, i_DAddr, i_MemData;
  logic        o_MemRd;
  logic [31:0] o_MemAddr, o_Fill_Data;
  logic [1:0]  o_Fill_Idx;
  logic        o_IFill_We, o_DFill_We, o_IDone, o_DDone;

  miss_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_IReq(i_IReq), .i_IAddr(i_IAddr), .i_DReq(i_DReq), .i_DAddr(i_DAddr),
    .o_MemRd(o_MemRd), .o_MemAddr(o_MemAddr), .i_MemValid(i_MemValid), .i_MemData(i_MemData),
    .o_Fill_Data(o_Fill_Data), .o_Fill_Idx(o_Fill_Idx),
    .o_IFill_We(o_IFill_We), .o_DFill_We(o_DFill_We), .o_IDone(o_IDone), .o_DDone(o_DDone)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- line-level reference model ----------------
  bit          m_job, m_own_d, m_flush;
  logic [31:0] m_base;
  int          m_q[$];
  bit          e_rd, e_ifwe, e_dfwe, e_idone, e_ddone;
  logic [31:0] e_addr, e_data;
  int          e_idx;
  bit          p_ireq, p_dreq, p_valid;
  logic [31:0] p_iaddr, p_daddr, p_data;

  function automatic void model_reset();
    m_job = 0; m_own_d = 0; m_flush = 0; m_base = 0; m_q.delete();
    e_rd = 0; e_addr = 0; e_data = 0; e_idx = 0;
    e_ifwe = 0; e_dfwe = 0; e_idone = 0; e_ddone = 0;
  endfunction

  function automatic void model_step();
    logic [31:0] a;
    int          st, w;
    bit          oreq;
    e_ifwe = 0; e_dfwe = 0; e_idone = 0; e_ddone = 0;
    if (!m_job) begin
      if (p_dreq || p_ireq) begin
        m_own_d = p_dreq;
        a       = p_dreq ? p_daddr : p_iaddr;
        m_base  = a & ~32'(LW * 4 - 1);
        st      = CRIT ? int'((a >> 2) % LW) : 0;
        m_q.delete();
        for (int k = 0; k < LW; k++) m_q.push_back((st + k) % LW);
        m_job = 1; m_flush = 0;
        e_rd = 1; e_addr = m_base + 32'(m_q[0] * 4);
      end
    end else begin
      oreq = m_own_d ? p_dreq : p_ireq;
      if (e_rd) begin
        if (!oreq) m_flush = 1;
        if (p_valid) begin
          w = m_q.pop_front();
          e_rd = 0;
          if (!m_flush) begin
            e_data = p_data; e_idx = w;
            e_dfwe = m_own_d; e_ifwe = !m_own_d;
            e_ddone = m_own_d && (m_q.size() == 0);
            e_idone = !m_own_d && (m_q.size() == 0);
          end
        end
      end else if (m_q.size() == 0 || m_flush || !oreq) begin
        m_job = 0;
      end else begin
        e_rd = 1; e_addr = m_base + 32'(m_q[0] * 4);
      end
    end
  endfunction

  // ---------------- per-cycle driver / monitor ----------------
  int          cyc = 0;
  int          lat = 2, cur_lat = 2, rd_age = 0;
  bit          rand_en = 0, prev_rd = 0;
  int          cnt_ifill = 0, cnt_dfill = 0, cnt_idone = 0, cnt_ddone = 0, cnt_acc = 0;
  int          last_ddone_cyc = 0, done_idx = 0;
  logic [31:0] acc_q[$];
  int          fill_idx_q[$], fill_own_q[$], rise_q[$];

  task automatic tick();
    bit rel_i, rel_d;
    p_ireq = i_IReq; p_dreq = i_DReq; p_iaddr = i_IAddr; p_daddr = i_DAddr;
    p_valid = i_MemValid; p_data = i_MemData;
    @(negedge Clk);
    cyc++;
    model_step();
    check("mem_rd", 32'(o_MemRd), 32'(e_rd));
    if (e_rd) check("mem_addr", o_MemAddr, e_addr);
    check("ifill_we", 32'(o_IFill_We), 32'(e_ifwe));
    check("dfill_we", 32'(o_DFill_We), 32'(e_dfwe));
    check("idone", 32'(o_IDone), 32'(e_idone));
    check("ddone", 32'(o_DDone), 32'(e_ddone));
    if (e_ifwe || e_dfwe) begin
      check("fill_data", o_Fill_Data, e_data);
      check("fill_idx", 32'(o_Fill_Idx), 32'(e_idx));
    end
    if (o_MemRd && !prev_rd) rise_q.push_back(cyc);
    prev_rd = o_MemRd;
    if (o_IFill_We) begin cnt_ifill++; fill_idx_q.push_back(int'(o_Fill_Idx)); fill_own_q.push_back(0); end
    if (o_DFill_We) begin cnt_dfill++; fill_idx_q.push_back(int'(o_Fill_Idx)); fill_own_q.push_back(1); end
    rel_i = 0; rel_d = 0;
    if (o_IDone) begin cnt_idone++; done_idx = int'(o_Fill_Idx); i_IReq = 0; rel_i = 1; end
    if (o_DDone) begin cnt_ddone++; done_idx = int'(o_Fill_Idx); i_DReq = 0; rel_d = 1; last_ddone_cyc = cyc; end
    // memory responder
    if (o_MemRd) begin
      if (rd_age == 0) cur_lat = rand_en ? int'($urandom_range(0, 4)) : lat;
      if (rd_age >= cur_lat) begin
        i_MemValid = 1; i_MemData = $urandom; rd_age = 0;
        acc_q.push_back(o_MemAddr); cnt_acc++;
      end else begin
        i_MemValid = 0; rd_age++;
      end
    end else begin
      rd_age = 0;
      i_MemValid = rand_en && ($urandom_range(0, 3) == 0);
      i_MemData = $urandom;
    end
    if (rand_en) begin
      if (!rel_i) begin
        if (!i_IReq && $urandom_range(0, 7) == 0) begin i_IAddr = $urandom; i_IReq = 1; end
        else if (i_IReq && $urandom_range(0, 63) == 0) i_IReq = 0;
      end
      if (!rel_d) begin
        if (!i_DReq && $urandom_range(0, 7) == 0) begin i_DAddr = $urandom; i_DReq = 1; end
        else if (i_DReq && $urandom_range(0, 63) == 0) i_DReq = 0;
      end
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_memrd"}, 32'(o_MemRd), 0);
    check({nm, "_memaddr"}, o_MemAddr, 0);
    check({nm, "_filldata"}, o_Fill_Data, 0);
    check({nm, "_fillidx"}, 32'(o_Fill_Idx), 0);
    check({nm, "_we"}, 32'({o_IFill_We, o_DFill_We}), 0);
    check({nm, "_done"}, 32'({o_IDone, o_DDone}), 0);
  endtask

  // ---------------- directed line table ----------------
  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    int          l;
    logic [31:0] ea[4];
    int          ei[4];
  } vec_t;
  vec_t tbl[4];

  function automatic vec_t mk(bit d, logic [31:0] a, int l, logic [31:0] a0, logic [31:0] a1,
                              logic [31:0] a2, logic [31:0] a3, int i0, int i1, int i2, int i3);
    vec_t v;
    v.is_d = d; v.addr = a; v.l = l;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    v.ei[0] = i0; v.ei[1] = i1; v.ei[2] = i2; v.ei[3] = i3;
    return v;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, i0, f0, k;
    logic [31:0] a0;
    if (CRIT) begin
      tbl[0] = mk(0, 32'h104, 2, 32'h104, 32'h108, 32'h10C, 32'h100, 1, 2, 3, 0);
      tbl[1] = mk(1, 32'h2000_003B, 0, 32'h2000_0038, 32'h2000_003C, 32'h2000_0030, 32'h2000_0034, 2, 3, 0, 1);
      tbl[2] = mk(0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 3, 0, 1, 2);
      tbl[3] = mk(1, 32'h8, 3, 32'h8, 32'hC, 32'h0, 32'h4, 2, 3, 0, 1);
    end else begin
      tbl[0] = mk(0, 32'h104, 2, 32'h100, 32'h104, 32'h108, 32'h10C, 0, 1, 2, 3);
      tbl[1] = mk(1, 32'h2000_003B, 0, 32'h2000_0030, 32'h2000_0034, 32'h2000_0038, 32'h2000_003C, 0, 1, 2, 3);
      tbl[2] = mk(0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 1, 2, 3);
      tbl[3] = mk(1, 32'h8, 3, 32'h0, 32'h4, 32'h8, 32'hC, 0, 1, 2, 3);
    end

    Rst = 1; i_IReq = 0; i_DReq = 0; i_IAddr = 0; i_DAddr = 0; i_MemValid = 0; i_MemData = 0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Rst = 0;
    repeat (2) tick();

    // table-driven single-line refills
    for (int t = 0; t < 4; t++) begin
      acc_q.delete(); fill_idx_q.delete(); fill_own_q.delete();
      lat = tbl[t].l;
      if (tbl[t].is_d) begin i_DAddr = tbl[t].addr; i_DReq = 1; end
      else begin i_IAddr = tbl[t].addr; i_IReq = 1; end
      d0 = tbl[t].is_d ? cnt_ddone : cnt_idone;
      k = 0;
      while (k < 200 && (tbl[t].is_d ? cnt_ddone : cnt_idone) == d0) begin tick(); k++; end
      check("tbl_done_seen", 32'((tbl[t].is_d ? cnt_ddone : cnt_idone) != d0), 1);
      check("tbl_done_idx", 32'(done_idx), 32'(tbl[t].ei[3]));
      check("tbl_nacc", 32'(acc_q.size()), 4);
      check("tbl_nfill", 32'(fill_idx_q.size()), 4);
      for (int j = 0; j < 4; j++) begin
        if (j < acc_q.size()) check("tbl_addr", acc_q[j], tbl[t].ea[j]);
        if (j < fill_idx_q.size()) begin
          check("tbl_idx", 32'(fill_idx_q[j]), 32'(tbl[t].ei[j]));
          check("tbl_owner", 32'(fill_own_q[j]), 32'(tbl[t].is_d));
        end
      end
      repeat (2) tick();
    end

    // simultaneous misses: D line, one idle cycle, then I line
    fill_own_q.delete(); rise_q.delete(); lat = 1;
    i_IAddr = 32'h4008; i_DAddr = 32'h3000; i_IReq = 1; i_DReq = 1;
    i0 = cnt_idone;
    k = 0;
    while (k < 300 && cnt_idone == i0) begin tick(); k++; end
    check("sim_both_done", 32'(cnt_idone != i0), 1);
    check("sim_nfill", 32'(fill_own_q.size()), 8);
    for (int j = 0; j < 8 && j < fill_own_q.size(); j++)
      check("sim_order", 32'(fill_own_q[j]), (j < 4) ? 32'd1 : 32'd0);
    k = -1;
    foreach (rise_q[j]) if (k < 0 && rise_q[j] > last_ddone_cyc) k = rise_q[j];
    check("sim_gap", 32'(k - last_ddone_cyc), 2);
    repeat (2) tick();

    // flush mid-line with a pending D request
    lat = 2; i_IAddr = 32'h500; i_IReq = 1;
    f0 = cnt_ifill; k = 0;
    while (k < 100 && cnt_ifill - f0 < 2) begin tick(); k++; end
    check("flush_two_fills", 32'(cnt_ifill - f0), 2);
    i_DAddr = 32'h640; i_DReq = 1;
    tick();
    i_IReq = 0;
    acc_q.delete(); f0 = cnt_ifill; i0 = cnt_idone; d0 = cnt_ddone;
    k = 0;
    while (k < 200 && cnt_ddone == d0) begin tick(); k++; end
    check("flush_d_done", 32'(cnt_ddone != d0), 1);
    check("flush_no_ifill", 32'(cnt_ifill - f0), 0);
    check("flush_no_idone", 32'(cnt_idone - i0), 0);
    check("flush_inflight", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD, 32'h508);
    check("flush_d_first", (acc_q.size() > 1) ? acc_q[1] : 32'hDEAD, 32'h640);
    repeat (2) tick();

    // memory stall: valid held low for 10 cycles
    lat = 10; i_IAddr = 32'h700; i_IReq = 1;
    k = 0;
    while (k < 20 && !o_MemRd) begin tick(); k++; end
    a0 = o_MemAddr;
    f0 = cnt_ifill;
    for (int j = 0; j < 10; j++) begin
      check("stall_rd", 32'(o_MemRd), 1);
      check("stall_addr", o_MemAddr, CRIT ? 32'h700 : 32'h700);
      check("stall_addr_hold", o_MemAddr, a0);
      tick();
    end
    check("stall_no_fill", 32'(cnt_ifill - f0), 0);
    lat = 2; i0 = cnt_idone; k = 0;
    while (k < 100 && cnt_idone == i0) begin tick(); k++; end
    check("stall_done", 32'(cnt_idone != i0), 1);
    repeat (2) tick();

    // asynchronous reset while a read is outstanding
    lat = 3; i_IAddr = 32'h800; i_IReq = 1;
    k = 0;
    while (k < 20 && !o_MemRd) begin tick(); k++; end
    check("arst_rd_before", 32'(o_MemRd), 1);
    @(posedge Clk);
    #2 Rst = 1;
    #1 check_all_zero("arst");
    @(negedge Clk);
    i_IReq = 0; i_MemValid = 0; rd_age = 0;
    @(negedge Clk);
    Rst = 0;
    model_reset();
    f0 = cnt_ifill; i0 = cnt_idone;
    repeat (10) tick();
    check("arst_no_fill", 32'(cnt_ifill - f0), 0);
    check("arst_no_done", 32'(cnt_idone - i0), 0);

    // random traffic against the model
    i0 = cnt_idone + cnt_ddone;
    rand_en = 1;
    repeat (4000) tick();
    rand_en = 0; i_IReq = 0; i_DReq = 0;
    repeat (30) tick();
    check("rand_lines", 32'((cnt_idone + cnt_ddone) > i0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
